// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned CNT_W            = 2;
    localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order shift FIFO; slot 0 is always the head so it can drive outputs directly.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned   PW         = 64,
    parameter logic [PW-1:0] RESET_HEAD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [PW-1:0]    push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [PW-1:0]    head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PW-1:0]    slot0_q, slot0_d;
    logic [PW-1:0]    slot1_q, slot1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    assign full_o  = (count_q == CNT_W'(2));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = slot0_q;

    // Next slot contents; the head slot is left untouched when the FIFO empties.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        if (flush_i) begin
            count_d = '0;
        end else begin
            case (count_q)
                CNT_W'(0): begin
                    if (do_push) begin
                        slot0_d = push_data_i;
                        count_d = CNT_W'(1);
                    end
                end
                CNT_W'(1): begin
                    if (do_push && do_pop) begin
                        slot0_d = push_data_i;
                    end else if (do_push) begin
                        slot1_d = push_data_i;
                        count_d = CNT_W'(2);
                    end else if (do_pop) begin
                        count_d = '0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        slot0_d = slot1_q;
                        if (do_push) slot1_d = push_data_i;
                        else         count_d = CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0_q <= RESET_HEAD;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: issues sequential requests, buffers tagged responses, handles redirects.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam int unsigned   PW         = AWIDTH + DWIDTH;
    localparam logic [PW-1:0] RESET_HEAD = {BASEADDR, DWIDTH'(NOP_INSN)};

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  stale_q, stale_d;
    logic              req_valid_q, req_valid_d;
    logic [CNT_W-1:0]  cnt_d;

    logic              req_hs;
    logic              rsp_ok;
    logic [AWIDTH-1:0] rsp_pc;
    logic              fifo_push;
    logic              fifo_pop;
    logic [PW-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign req_hs    = req_valid_q && imem_req_ready_i;
    assign rsp_ok    = imem_rsp_valid_i && ((out_q != '0) || req_hs);
    // In RUN every outstanding request is live, so the oldest one sits out_q words behind fetch-PC.
    assign rsp_pc    = fetch_pc_q - (AWIDTH'(out_q) << 2);
    assign fifo_push = rsp_ok && (state_q == ST_RUN) && !redirect_i && !fifo_full;
    assign fifo_pop  = !fifo_empty && ready_i;

    fetch_fifo #(
        .PW         (PW),
        .RESET_HEAD (RESET_HEAD)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({rsp_pc, imem_rsp_data_i}),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_i),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign imem_req_valid_o = req_valid_q;
    assign imem_addr_o      = fetch_pc_q;
    assign valid_o          = !fifo_empty;
    assign pc_o             = fifo_head[PW-1:DWIDTH];
    assign insn_o           = fifo_head[DWIDTH-1:0];

    // Next fetch-PC, RUN/DRAIN transitions, in-flight bookkeeping and request credit.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        stale_d    = stale_q;
        out_d      = out_q + CNT_W'(req_hs) - CNT_W'(rsp_ok);
        if (req_hs) fetch_pc_d = fetch_pc_q + AWIDTH'(4);
        if (state_q == ST_DRAIN) begin
            stale_d = stale_q - CNT_W'(rsp_ok);
            if (stale_d == '0) state_d = ST_RUN;
        end
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~AWIDTH'(3);
            stale_d    = out_d;
            state_d    = (out_d != '0) ? ST_DRAIN : ST_RUN;
        end
        cnt_d       = redirect_i ? '0 : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        req_valid_d = (state_d == ST_RUN) &&
                      (({1'b0, out_d} + {1'b0, cnt_d}) < 3'd2);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fetch_pc_q  <= BASEADDR;
            out_q       <= '0;
            stale_q     <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            out_q       <= out_d;
            stale_q     <= stale_d;
            req_valid_q <= req_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Randomized self-checking bench for fetch against a queue-based behavioural model.
module tb_fetch;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;

    fetch dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .insn_o           (insn_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus knobs (percent, redirect in per mille).
    int unsigned p_ready, p_mready, p_rsp, p_zw, p_redir;

    // Behavioural model: requests in flight, decode-side buffer, displayed entry, fetch PC.
    req_t        infl[$];
    ent_t        mbuf[$];
    ent_t        shown;
    logic [31:0] mpc;

    // Memory environment and logs of observed activity.
    logic [31:0] mq[$];
    logic [31:0] hs_log[$];
    logic [31:0] deliv_pc[$];
    int          deliv_cyc[$];

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic bit exp_rv();
        foreach (infl[i]) if (infl[i].stale) return 1'b0;
        return (infl.size() + mbuf.size()) < 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        infl.delete();
        mbuf.delete();
        mq.delete();
        mpc   = BASE;
        shown = '{pc: BASE, insn: NOP};
    endtask

    task automatic drive_idle();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        ready_i          = 1'b0;
    endtask

    task automatic flow();
        p_ready = 100; p_mready = 100; p_rsp = 100; p_zw = 100; p_redir = 0;
    endtask

    task automatic clear_logs();
        hs_log.delete();
        deliv_pc.delete();
        deliv_cyc.delete();
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input bit force_redir, input logic [31:0] tgt);
        bit          mready, hs_a, hs_m, rv, same, redir, pop_m;
        logic [31:0] raddr, rtgt;
        req_t        e;
        @(negedge clk);
        cyc++;
        chk("req_valid", 32'(imem_req_valid_o), 32'(exp_rv()));
        if (exp_rv()) chk("req_addr", imem_addr_o, mpc);
        chk("valid", 32'(valid_o), 32'(mbuf.size() != 0));
        chk("pc", pc_o, shown.pc);
        chk("insn", insn_o, shown.insn);

        mready = $urandom_range(99) < p_mready;
        hs_a   = imem_req_valid_o && mready;
        rv = 1'b0; same = 1'b0; raddr = '0;
        if (mq.size() != 0 && $urandom_range(99) < p_rsp) begin
            rv = 1'b1; raddr = mq.pop_front();
        end else if (mq.size() == 0 && hs_a && $urandom_range(99) < p_zw) begin
            rv = 1'b1; raddr = imem_addr_o; same = 1'b1;
        end
        if (hs_a && !same) mq.push_back(imem_addr_o);
        if (hs_a) hs_log.push_back(imem_addr_o);
        redir = force_redir || ($urandom_range(999) < p_redir);
        rtgt  = force_redir ? tgt : $urandom;

        imem_req_ready_i = mready;
        imem_rsp_valid_i = rv;
        imem_rsp_data_i  = rv ? hashf(raddr) : $urandom;
        ready_i          = $urandom_range(99) < p_ready;
        redirect_i       = redir;
        redirect_pc_i    = rtgt;
        if (valid_o && ready_i) begin
            deliv_pc.push_back(pc_o);
            deliv_cyc.push_back(cyc);
        end

        hs_m  = exp_rv() && mready;
        pop_m = (mbuf.size() != 0) && ready_i;
        if (hs_m) infl.push_back('{pc: mpc, stale: redir});
        if (pop_m) void'(mbuf.pop_front());
        if (rv) begin
            if (infl.size() == 0) begin
                errors++;
                $display("FAIL rsp_orphan cycle %0d: got response expected none in flight", cyc);
            end else begin
                e = infl.pop_front();
                if (!e.stale && !redir) mbuf.push_back('{pc: e.pc, insn: hashf(e.pc)});
            end
        end
        if (redir) begin
            mbuf.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            mpc = {rtgt[31:2], 2'b00};
        end else if (hs_m) begin
            mpc = mpc + 32'd4;
        end
        if (mbuf.size() != 0) shown = mbuf[0];
    endtask

    initial begin
        drive_idle();
        flow();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_addr", imem_addr_o, BASE);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pc", pc_o, BASE);
        chk("rst_insn", insn_o, NOP);
        model_reset();
        rst = 1'b1;

        // Zero-wait streaming after reset.
        clear_logs();
        repeat (8) cycle(1'b0, '0);
        chk("stream_addr0", at(hs_log, 0), 32'h0100_0000);
        chk("stream_addr1", at(hs_log, 1), 32'h0100_0004);
        chk("stream_addr2", at(hs_log, 2), 32'h0100_0008);
        chk("stream_pc0", at(deliv_pc, 0), 32'h0100_0000);
        chk("stream_pc1", at(deliv_pc, 1), 32'h0100_0004);
        chk("stream_pc2", at(deliv_pc, 2), 32'h0100_0008);
        chk("stream_rate", (deliv_cyc.size() >= 3) ? 32'(deliv_cyc[2] - deliv_cyc[0]) : 32'hFFFF, 32'd2);

        // Decode stall fills the buffer and throttles requests.
        p_ready = 0;
        repeat (5) cycle(1'b0, '0);
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_no_req", 32'(imem_req_valid_o), 32'd0);
        p_ready = 100;
        repeat (6) cycle(1'b0, '0);

        // Redirect with two requests outstanding, then drain.
        p_rsp = 0; p_zw = 0;
        repeat (5) cycle(1'b0, '0);
        cycle(1'b1, 32'h0100_0203);
        @(posedge clk);
        #1;
        chk("drain_no_req", 32'(imem_req_valid_o), 32'd0);
        chk("drain_no_valid", 32'(valid_o), 32'd0);
        flow();
        clear_logs();
        repeat (8) cycle(1'b0, '0);
        chk("redir_addr", at(hs_log, 0), 32'h0100_0200);
        chk("redir_pc", at(deliv_pc, 0), 32'h0100_0200);

        // Redirect coinciding with a response and a pop.
        repeat (4) cycle(1'b0, '0);
        clear_logs();
        cycle(1'b1, 32'h0200_0010);
        repeat (6) cycle(1'b0, '0);
        chk("coinc_pc1", at(deliv_pc, 1), 32'h0200_0010);
        chk("coinc_pc2", at(deliv_pc, 2), 32'h0200_0014);

        // Fetch-PC wrap.
        cycle(1'b1, 32'hFFFF_FFFC);
        clear_logs();
        repeat (5) cycle(1'b0, '0);
        chk("wrap_addr0", at(hs_log, 0), 32'hFFFF_FFFC);
        chk("wrap_addr1", at(hs_log, 1), 32'h0000_0000);

        // Randomized traffic with random redirects.
        for (int blk = 0; blk < 6; blk++) begin
            p_ready  = $urandom_range(100, 20);
            p_mready = $urandom_range(100, 20);
            p_rsp    = $urandom_range(100, 20);
            p_zw     = $urandom_range(100, 0);
            p_redir  = $urandom_range(50, 0);
            repeat (500) cycle(1'b0, '0);
        end

        // Reset in the middle of a stalled stream.
        flow();
        repeat (4) cycle(1'b0, '0);
        p_ready = 0;
        repeat (4) cycle(1'b0, '0);
        chk("pre_reset_full", 32'(valid_o && !imem_req_valid_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("mid_rst_addr", imem_addr_o, BASE);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_pc", pc_o, BASE);
        chk("mid_rst_insn", insn_o, NOP);
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        flow();
        clear_logs();
        repeat (6) cycle(1'b0, '0);
        chk("refetch_addr0", at(hs_log, 0), 32'h0100_0000);
        chk("refetch_addr1", at(hs_log, 1), 32'h0100_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address/PC width.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction width.
REQ-003 SHALL have parameter BASEADDR, default 32'h0100_0000, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_req_valid_o  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready_i  input  1  memory accepts request.
REQ-008 SHALL have port imem_addr_o  output  AWIDTH  fetch address.
REQ-009 SHALL have port imem_rsp_valid_i  input  1  in-order response valid; no backpressure.
REQ-010 SHALL have port imem_rsp_data_i  input  DWIDTH  fetched instruction.
REQ-011 SHALL have port redirect_i  input  1  branch/jump redirect pulse.
REQ-012 SHALL have port redirect_pc_i  input  AWIDTH  redirect target.
REQ-013 SHALL have port valid_o  output  1  pc_o/insn_o valid toward decode.
REQ-014 SHALL have port ready_i  input  1  decode accepts entry.
REQ-015 SHALL have port pc_o  output  AWIDTH  PC of delivered instruction.
REQ-016 SHALL have port insn_o  output  DWIDTH  delivered instruction.

Function
REQ-017 SHALL keep fetch-PC register; a request handshake (req_valid & req_ready) SHALL advance it by 4, wrapping modulo 2^AWIDTH.
REQ-018 SHALL drive imem_addr_o = fetch-PC whenever imem_req_valid_o is 1, stable until handshake.
REQ-019 SHALL assert imem_req_valid_o only in RUN and only while (outstanding + FIFO occupancy) < 2.
REQ-020 SHALL buffer responses with PC tag in a 2-entry in-order FIFO; response-to-valid_o latency exactly 1 cycle.
REQ-021 SHALL present FIFO head on pc_o/insn_o; entry pops on valid_o & ready_i; pc_o/insn_o SHALL be stable while valid_o & !ready_i.
REQ-022 SHALL support simultaneous push and pop with full throughput (one insn/cycle with zero-wait memory, ready_i=1).
REQ-023 SHALL hold pc_o/insn_o at last values when valid_o=0.
REQ-024 SHALL on redirect_i: flush FIFO, load fetch-PC with redirect_pc_i with bits [1:0] forced to 0, mark all outstanding requests stale.
REQ-025 SHALL count a request handshaking in the redirect cycle as stale; a response arriving in the redirect cycle SHALL be discarded.
REQ-026 SHALL treat a pop coinciding with redirect as completed; the entry is not re-delivered.
REQ-027 SHALL implement FSM RUN/DRAIN: redirect with stale count >0 -> DRAIN; DRAIN discards responses, issues no requests; stale count 0 -> RUN next cycle; redirect with stale count 0 stays RUN.
REQ-028 SHALL treat redirect while in DRAIN as restart: new target loaded, stale count includes all outstanding.
REQ-029 SHALL never overflow FIFO; response with FIFO full is impossible by REQ-019.

Reset
REQ-030 SHALL on rst=0 asynchronously set: fetch-PC=BASEADDR, state=RUN, FIFO empty, outstanding=0, stale=0.
REQ-031 SHALL reset outputs: imem_req_valid_o=0, imem_addr_o=BASEADDR, valid_o=0, pc_o=BASEADDR, insn_o=32'h0000_0013 (NOP).
REQ-032 SHALL issue first request in the first clk edge cycle after rst deasserts; reset mid-operation discards all in-flight state.

Structure
REQ-033 SHALL take BASEADDR default, NOP encoding and RUN/DRAIN state enum from the shared constants package.
REQ-034 SHALL instantiate one sub-module fetch_fifo (2-entry, {pc,insn} payload, push/pop/full/empty/count).

Verification
REQ-035 Reset release, zero-wait memory, ready_i=1 -> addresses 0x0100_0000, 0x0100_0004, 0x0100_0008 issued; valid_o one cycle after each response, one insn/cycle.
REQ-036 ready_i=0 for 5 cycles -> FIFO fills at 2, imem_req_valid_o drops, pc_o/insn_o stable; ready_i=1 -> in-order drain, no loss.
REQ-037 Redirect to 0x0100_0203 with 2 outstanding -> DRAIN, 2 responses discarded, next request address 0x0100_0200, no stale insn on valid_o.
REQ-038 Redirect same cycle as response and as pop -> response dropped, popped entry not repeated, next valid_o pc = target.
REQ-039 fetch-PC = 0xFFFF_FFFC handshake -> next address 0x0000_0000.
REQ-040 rst asserted mid-stream with full FIFO -> outputs immediately at reset values; refetch from 0x0100_0000.
